// File: rtl/mem_fetch.sv
// mem_fetch: read-fetch sequencer between the evaluator core and a one-cycle-latency RAM.
// Define FETCH_CACHE_EN to add a one-entry last-address cache that bypasses the RAM on a hit.
package mem_fetch_pkg;
    typedef enum logic {mem_ok = 1'b0, mem_oob = 1'b1} mem_status_t;
endpackage

module mem_fetch
    import mem_fetch_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_W    = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic                 ram_rden,
    output logic                 ram_wren,
    input  logic [WORD_SIZE-1:0] ram_q,
    input  mem_status_t          ram_status,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_SIZE-1:0] resp_data,
    output logic                 resp_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 cache_inv
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    state_t state, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic accept, hit, oob;
    logic [WORD_SIZE-1:0] hit_data;
    assign accept     = state == S_IDLE && req_valid;
    assign oob        = ram_status == mem_oob;
    assign req_ready  = state == S_IDLE;
    assign ram_rden   = state == S_ISSUE;
    assign ram_addr   = addr_q;
    assign ram_wren   = 1'b0;
    assign resp_valid = state == S_RESP;
    assign busy       = state != S_IDLE;
`ifdef FETCH_CACHE_EN
    logic                 cache_vld;
    logic [ADDR_W-1:0]    cache_tag;
    logic [WORD_SIZE-1:0] cache_data;
    assign hit      = cache_vld && cache_tag == req_addr && !cache_inv;
    assign hit_data = cache_data;
    // invalidate takes priority over a fill landing in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld  <= 1'b0;
            cache_tag  <= '0;
            cache_data <= '0;
        end else if (cache_inv) begin
            cache_vld <= 1'b0;
        end else if (state == S_WAIT && !oob) begin
            cache_vld  <= 1'b1;
            cache_tag  <= addr_q;
            cache_data <= ram_q;
        end
    end
`else
    logic unused_cache_inv;
    assign unused_cache_inv = cache_inv;
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  state_d = req_valid ? (hit ? S_RESP : S_ISSUE) : S_IDLE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_RESP;
            S_RESP:  state_d = resp_ready ? S_IDLE : S_RESP;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            err_count <= '0;
        end else begin
            state <= state_d;
            if (accept) addr_q <= req_addr;
            if (state == S_WAIT) begin
                resp_data <= ram_q;
                resp_err  <= oob;
                if (oob && !(&err_count)) err_count <= err_count + ERR_CNT_W'(1);
            end else if (accept && hit) begin
                resp_data <= hit_data;
                resp_err  <= 1'b0;
            end
        end
    end
endmodule
